// File: rtl/mvp_xform.sv
// mvp_xform: sequences a 4x4 signed Q8.8 matrix times a vertex through an external dot-product unit.
// Define XFORM_SKIP_W_EN to issue rows 0..2 only; out_w then reads 1.0 (0x0100).
module mvp_xform (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mat_we,
   input  logic [3:0]  mat_addr,
   input  logic [15:0] mat_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_x,
   input  logic [15:0] in_y,
   input  logic [15:0] in_z,
   input  logic [15:0] in_w,
   output logic        dp_start,
   output logic [15:0] dp_a_x,
   output logic [15:0] dp_a_y,
   output logic [15:0] dp_a_z,
   output logic [15:0] dp_a_w,
   output logic [15:0] dp_b_x,
   output logic [15:0] dp_b_y,
   output logic [15:0] dp_b_z,
   output logic [15:0] dp_b_w,
   input  logic        dp_done,
   input  logic [15:0] dp_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_x,
   output logic [15:0] out_y,
   output logic [15:0] out_z,
   output logic [15:0] out_w,
   output logic [1:0]  dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both
   // high; the offering side keeps valid and its payload steady until that edge.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

`ifdef XFORM_SKIP_W_EN
   localparam logic [1:0] LAST_ROW = 2'd2;
`else
   localparam logic [1:0] LAST_ROW = 2'd3;
`endif

   state_t      state, state_nx;
   logic [1:0]  row, row_nx;
   logic [15:0] mat [16];
   logic [15:0] vtx_x, vtx_y, vtx_z, vtx_w;
   logic        accept;
   logic        op_live;

   assign accept    = in_valid && in_ready;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         row   <= 2'd0;
      end else begin
         state <= state_nx;
         row   <= row_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      row_nx    = row;
      in_ready  = 1'b0;
      dp_start  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               row_nx   = 2'd0;
               state_nx = S_ISSUE;
            end
         end
         S_ISSUE: begin
            dp_start = 1'b1;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (dp_done) begin
               if (row == LAST_ROW) begin
                  state_nx = S_OUT;
               end else begin
                  row_nx   = row + 2'd1;
                  state_nx = S_ISSUE;
               end
            end
         end
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Writes are only honoured in IDLE, so the row driven on dp_a cannot move mid-vertex.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) mat[i] <= (i % 5 == 0) ? 16'h0100 : 16'h0000;
      end else if (mat_we && state == S_IDLE) begin
         mat[mat_addr] <= mat_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vtx_x <= 16'h0000;
         vtx_y <= 16'h0000;
         vtx_z <= 16'h0000;
         vtx_w <= 16'h0000;
         out_x <= 16'h0000;
         out_y <= 16'h0000;
         out_z <= 16'h0000;
         out_w <= 16'h0000;
      end else begin
         if (accept) begin
            vtx_x <= in_x;
            vtx_y <= in_y;
            vtx_z <= in_z;
            vtx_w <= in_w;
         end
         if (state == S_WAIT && dp_done) begin
            case (row)
               2'd0:    out_x <= dp_result;
               2'd1:    out_y <= dp_result;
               2'd2:    out_z <= dp_result;
               default: out_w <= dp_result;
            endcase
`ifdef XFORM_SKIP_W_EN
            if (row == LAST_ROW) out_w <= 16'h0100;
`endif
         end
      end
   end

   // Row operands are only presented while a dot product is in flight.
   assign op_live = (state == S_ISSUE) || (state == S_WAIT);
   assign dp_a_x  = op_live ? mat[{row, 2'd0}] : 16'h0000;
   assign dp_a_y  = op_live ? mat[{row, 2'd1}] : 16'h0000;
   assign dp_a_z  = op_live ? mat[{row, 2'd2}] : 16'h0000;
   assign dp_a_w  = op_live ? mat[{row, 2'd3}] : 16'h0000;
   assign dp_b_x  = vtx_x;
   assign dp_b_y  = vtx_y;
   assign dp_b_z  = vtx_z;
   assign dp_b_w  = vtx_w;

endmodule

// File: tb/tb_mvp_xform.sv
// tb_mvp_xform: randomized bench for mvp_xform with an inline dot-unit model and a
// matrix/vertex reference model; honours XFORM_SKIP_W_EN when defined.
`timescale 1ns/1ps
module tb_mvp_xform;

`ifdef XFORM_SKIP_W_EN
   localparam bit SKIP_W = 1'b1;
`else
   localparam bit SKIP_W = 1'b0;
`endif
   localparam int ROWS = SKIP_W ? 3 : 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mat_we;
   logic [3:0]  mat_addr;
   logic [15:0] mat_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_x, in_y, in_z, in_w;
   logic        dp_start;
   logic [15:0] dp_a_x, dp_a_y, dp_a_z, dp_a_w;
   logic [15:0] dp_b_x, dp_b_y, dp_b_z, dp_b_w;
   logic        dp_done;
   logic [15:0] dp_result;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_x, out_y, out_z, out_w;
   logic [1:0]  dbg_state;

   int          n_checks;
   int          n_errors;
   logic [15:0] ref_m [16];
   logic [15:0] exp_q [$];

   mvp_xform dut (
      .clk(clk), .rst_n(rst_n),
      .mat_we(mat_we), .mat_addr(mat_addr), .mat_data(mat_data),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_w(in_w),
      .dp_start(dp_start),
      .dp_a_x(dp_a_x), .dp_a_y(dp_a_y), .dp_a_z(dp_a_z), .dp_a_w(dp_a_w),
      .dp_b_x(dp_b_x), .dp_b_y(dp_b_y), .dp_b_z(dp_b_z), .dp_b_w(dp_b_w),
      .dp_done(dp_done), .dp_result(dp_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_w(out_w),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Q8.8 dot product: full-precision sum, arithmetic shift by 8, keep low 16 bits.
   function automatic logic [15:0] dot4(input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
      longint s;
      s = longint'($signed(a0)) * longint'($signed(b0)) + longint'($signed(a1)) * longint'($signed(b1))
        + longint'($signed(a2)) * longint'($signed(b2)) + longint'($signed(a3)) * longint'($signed(b3));
      s = s >>> 8;
      return s[15:0];
   endfunction

   function automatic void push_expected(input logic [15:0] vx, vy, vz, vw);
      for (int r = 0; r < 4; r++) begin
         if (r == 3 && SKIP_W) exp_q.push_back(16'h0100);
         else exp_q.push_back(dot4(ref_m[r*4], ref_m[r*4+1], ref_m[r*4+2], ref_m[r*4+3], vx, vy, vz, vw));
      end
   endfunction

   task automatic write_mat(input logic [3:0] addr, input logic [15:0] data);
      mat_addr = addr;
      mat_data = data;
      mat_we   = 1'b1;
      @(negedge clk);
      mat_we   = 1'b0;
      ref_m[addr] = data;
   endtask

   // Offers one vertex, acts as a dot unit with d idle cycles, holds out_ready low for
   // `hold` cycles, then takes the result. Entered and left just after a falling edge.
   task automatic run_vertex(input logic [15:0] vx, vy, vz, vw, input int d, input int hold,
                             input bit acc_wr, input logic [3:0] acc_addr, input logic [15:0] acc_data,
                             input bit busy_wr, input logic [3:0] busy_addr, input logic [15:0] busy_data,
                             output logic [15:0] ox, oy, oz, ow, output int starts, output int lat,
                             output bit timeout, output bit ops_bad, output bit hold_bad);
      bit          acc;
      int          i_acc, cnt, n_done;
      logic [63:0] cap_a, cap_b;
      logic [15:0] res;
      acc = 0; i_acc = 0; cnt = 0; n_done = 0; starts = 0; lat = -1;
      timeout = 1; ops_bad = 0; hold_bad = 0; res = 16'h0;
      cap_a = 64'h0; cap_b = 64'h0;
      ox = 16'h0; oy = 16'h0; oz = 16'h0; ow = 16'h0;
      in_x = vx; in_y = vy; in_z = vz; in_w = vw; in_valid = 1'b1;
      if (acc_wr) begin
         mat_we = 1'b1; mat_addr = acc_addr; mat_data = acc_data;
      end
      for (int i = 0; i < 600; i++) begin
         dp_done = 1'b0;
         if (!acc) begin
            if (in_ready) begin
               acc = 1; i_acc = i;
            end
         end else begin
            in_valid = 1'b0;
            mat_we   = 1'b0;
            if (dp_start) begin
               starts++;
               cap_a = {dp_a_x, dp_a_y, dp_a_z, dp_a_w};
               cap_b = {dp_b_x, dp_b_y, dp_b_z, dp_b_w};
               res   = dot4(dp_a_x, dp_a_y, dp_a_z, dp_a_w, dp_b_x, dp_b_y, dp_b_z, dp_b_w);
               cnt   = d + 1;
            end else if (cnt > 0) begin
               if ({dp_a_x, dp_a_y, dp_a_z, dp_a_w} !== cap_a || {dp_b_x, dp_b_y, dp_b_z, dp_b_w} !== cap_b)
                  ops_bad = 1;
               cnt--;
               if (cnt == 0) begin
                  dp_done = 1'b1; dp_result = res; n_done++;
                  if (busy_wr && n_done == 1) begin
                     mat_we = 1'b1; mat_addr = busy_addr; mat_data = busy_data;
                  end
               end
            end
            if (out_valid) begin
               lat = i - i_acc - 1; timeout = 0;
               ox = out_x; oy = out_y; oz = out_z; ow = out_w;
               for (int h = 0; h < hold; h++) begin
                  @(negedge clk);
                  if (!out_valid || in_ready || dp_start || {out_x, out_y, out_z, out_w} !== {ox, oy, oz, ow})
                     hold_bad = 1;
               end
               out_ready = 1'b1;
               @(negedge clk);
               out_ready = 1'b0;
               break;
            end
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      mat_we   = 1'b0;
      dp_done  = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({dp_start, out_valid} !== 2'b00) begin
         n_errors++; $display("FAIL reset_ctrl: dp_start/out_valid=%b expected 00", {dp_start, out_valid});
      end
      n_checks++;
      if ({out_x, out_y, out_z, out_w} !== 64'h0) begin
         n_errors++; $display("FAIL reset_out: got %h expected 0", {out_x, out_y, out_z, out_w});
      end
      n_checks++;
      if ({dp_a_x, dp_a_y, dp_a_z, dp_a_w, dp_b_x, dp_b_y, dp_b_z, dp_b_w} !== 128'h0) begin
         n_errors++; $display("FAIL reset_operands: got %h expected 0",
                              {dp_a_x, dp_a_y, dp_a_z, dp_a_w, dp_b_x, dp_b_y, dp_b_z, dp_b_w});
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_identity();
      logic [15:0] ob [4];
      logic [15:0] e;
      int starts, lat;
      bit to, ob_bad, hb;
      push_expected(16'h0100, 16'h0200, 16'h0300, 16'h0100);
      run_vertex(16'h0100, 16'h0200, 16'h0300, 16'h0100, 0, 0, 0, 4'h0, 16'h0, 0, 4'h0, 16'h0,
                 ob[0], ob[1], ob[2], ob[3], starts, lat, to, ob_bad, hb);
      n_checks++;
      if (to || ob_bad) begin
         n_errors++; $display("FAIL identity_flow: timeout=%0d operand_unstable=%0d expected 0/0", to, ob_bad);
      end
      for (int r = 0; r < 4; r++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (ob[r] !== e) begin
            n_errors++; $display("FAIL identity_out[%0d]: got %h expected %h", r, ob[r], e);
         end
      end
      n_checks++;
      if (starts != ROWS) begin
         n_errors++; $display("FAIL identity_starts: got %0d expected %0d", starts, ROWS);
      end
      n_checks++;
      if (lat != ROWS * 2) begin
         n_errors++; $display("FAIL identity_latency: got %0d expected %0d", lat, ROWS * 2);
      end
   endtask

   task automatic test_row_load();
      logic [15:0] ob [4];
      logic [15:0] e, vy, vz, vw;
      int starts, lat;
      bit to, ob_bad, hb;
      write_mat(4'd0, 16'h0200);
      write_mat(4'd1, 16'h0000);
      write_mat(4'd2, 16'h0000);
      write_mat(4'd3, 16'h0000);
      vy = 16'($urandom); vz = 16'($urandom); vw = 16'($urandom);
      push_expected(16'h0180, vy, vz, vw);
      run_vertex(16'h0180, vy, vz, vw, 1, 0, 0, 4'h0, 16'h0, 0, 4'h0, 16'h0,
                 ob[0], ob[1], ob[2], ob[3], starts, lat, to, ob_bad, hb);
      n_checks++;
      if (ob[0] !== 16'h0300) begin
         n_errors++; $display("FAIL row_load_x: got %h expected 0300", ob[0]);
      end
      for (int r = 0; r < 4; r++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (ob[r] !== e) begin
            n_errors++; $display("FAIL row_load_out[%0d]: got %h expected %h", r, ob[r], e);
         end
      end
   endtask

   task automatic test_hold();
      logic [15:0] ob [4];
      logic [15:0] e, v [4];
      int starts, lat;
      bit to, ob_bad, hb;
      for (int k = 0; k < 4; k++) v[k] = 16'($urandom);
      push_expected(v[0], v[1], v[2], v[3]);
      run_vertex(v[0], v[1], v[2], v[3], 2, 10, 0, 4'h0, 16'h0, 0, 4'h0, 16'h0,
                 ob[0], ob[1], ob[2], ob[3], starts, lat, to, ob_bad, hb);
      n_checks++;
      if (to || hb) begin
         n_errors++; $display("FAIL hold_stable: timeout=%0d hold_violation=%0d expected 0/0", to, hb);
      end
      for (int r = 0; r < 4; r++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (ob[r] !== e) begin
            n_errors++; $display("FAIL hold_out[%0d]: got %h expected %h", r, ob[r], e);
         end
      end
   endtask

   task automatic test_busy_write();
      logic [15:0] ob [4];
      logic [15:0] e, v [4];
      logic [3:0]  a;
      int starts, lat;
      bit to, ob_bad, hb;
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 0; k < 4; k++) v[k] = 16'($urandom);
         a = 4'($urandom_range(0, 15));
         push_expected(v[0], v[1], v[2], v[3]);
         run_vertex(v[0], v[1], v[2], v[3], 1, 0, 0, 4'h0, 16'h0, pass == 0, a, ~ref_m[a],
                    ob[0], ob[1], ob[2], ob[3], starts, lat, to, ob_bad, hb);
         for (int r = 0; r < 4; r++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (ob[r] !== e) begin
               n_errors++; $display("FAIL busy_write_out[%0d] pass %0d: got %h expected %h", r, pass, ob[r], e);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] ob [4];
      logic [15:0] e, v [4], wd;
      logic [3:0]  wa;
      bit          aw;
      int starts, lat, d;
      bit to, ob_bad, hb;
      for (int it = 0; it < 16; it++) begin
         for (int n = $urandom_range(0, 3); n > 0; n--) write_mat(4'($urandom), 16'($urandom));
         for (int k = 0; k < 4; k++) v[k] = 16'($urandom);
         d  = $urandom_range(0, 4);
         aw = 1'($urandom);
         wa = 4'($urandom);
         wd = 16'($urandom);
         if (aw) ref_m[wa] = wd;
         push_expected(v[0], v[1], v[2], v[3]);
         run_vertex(v[0], v[1], v[2], v[3], d, $urandom_range(0, 2), aw, wa, wd, 0, 4'h0, 16'h0,
                    ob[0], ob[1], ob[2], ob[3], starts, lat, to, ob_bad, hb);
         n_checks++;
         if (to || ob_bad || hb) begin
            n_errors++; $display("FAIL random_flow it %0d: timeout=%0d operand_unstable=%0d hold=%0d expected 0",
                                 it, to, ob_bad, hb);
         end
         for (int r = 0; r < 4; r++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (ob[r] !== e) begin
               n_errors++; $display("FAIL random_out[%0d] it %0d: got %h expected %h", r, it, ob[r], e);
            end
         end
         n_checks++;
         if (starts != ROWS || lat != ROWS * (2 + d)) begin
            n_errors++; $display("FAIL random_timing it %0d: starts=%0d latency=%0d expected %0d/%0d",
                                 it, starts, lat, ROWS, ROWS * (2 + d));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ob [4];
      logic [15:0] e, v [4];
      int starts, lat;
      bit to, ob_bad, hb;
      for (int n = 0; n < 2; n++) begin
         for (int k = 0; k < 4; k++) v[k] = 16'($urandom);
         push_expected(v[0], v[1], v[2], v[3]);
         run_vertex(v[0], v[1], v[2], v[3], 0, 2, 0, 4'h0, 16'h0, 0, 4'h0, 16'h0,
                    ob[0], ob[1], ob[2], ob[3], starts, lat, to, ob_bad, hb);
         n_checks++;
         if (hb || in_ready !== 1'b1) begin
            n_errors++; $display("FAIL b2b_ready n %0d: hold_violation=%0d in_ready=%b expected 0/1", n, hb, in_ready);
         end
         for (int r = 0; r < 4; r++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (ob[r] !== e) begin
               n_errors++; $display("FAIL b2b_out[%0d] n %0d: got %h expected %h", r, n, ob[r], e);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] ob [4];
      logic [15:0] e, res, v [4];
      int starts, lat, cnt;
      bit acc, reached, to, ob_bad, hb, stray_bad;
      acc = 0; reached = 0; cnt = 0; starts = 0; res = 16'h0; stray_bad = 0;
      for (int k = 0; k < 4; k++) v[k] = 16'($urandom);
      in_x = v[0]; in_y = v[1]; in_z = v[2]; in_w = v[3]; in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         dp_done = 1'b0;
         if (!acc) begin
            if (in_ready) acc = 1;
         end else begin
            in_valid = 1'b0;
            if (dp_start) begin
               starts++;
               res = dot4(dp_a_x, dp_a_y, dp_a_z, dp_a_w, dp_b_x, dp_b_y, dp_b_z, dp_b_w);
               cnt = 4;
            end else if (cnt > 0) begin
               if (starts == 3) begin
                  reached = 1;
                  break;
               end
               cnt--;
               if (cnt == 0) begin
                  dp_done = 1'b1; dp_result = res;
               end
            end
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      n_checks++;
      if (!reached) begin
         n_errors++; $display("FAIL reset_mid_reach: row 2 wait reached=%0d expected 1", reached);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({dp_start, out_valid, out_x, out_y, out_z, out_w} !== 66'h0 ||
          {dp_a_x, dp_a_y, dp_a_z, dp_a_w, dp_b_x, dp_b_y, dp_b_z, dp_b_w} !== 128'h0) begin
         n_errors++; $display("FAIL reset_mid_outputs: out=%h a=%h b=%h expected all 0",
                              {out_x, out_y, out_z, out_w}, {dp_a_x, dp_a_y, dp_a_z, dp_a_w},
                              {dp_b_x, dp_b_y, dp_b_z, dp_b_w});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) ref_m[k] = (k % 5 == 0) ? 16'h0100 : 16'h0000;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++; $display("FAIL reset_mid_in_ready: got %b expected 1", in_ready);
      end
      dp_done = 1'b1; dp_result = 16'h7777;
      @(negedge clk);
      dp_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (out_valid || dp_start || !in_ready || {out_x, out_y, out_z, out_w} !== 64'h0) stray_bad = 1;
         @(negedge clk);
      end
      n_checks++;
      if (stray_bad) begin
         n_errors++; $display("FAIL reset_mid_stray_done: state disturbed=%0d expected 0", stray_bad);
      end
      for (int k = 0; k < 4; k++) v[k] = 16'($urandom);
      push_expected(v[0], v[1], v[2], v[3]);
      run_vertex(v[0], v[1], v[2], v[3], 1, 0, 0, 4'h0, 16'h0, 0, 4'h0, 16'h0,
                 ob[0], ob[1], ob[2], ob[3], starts, lat, to, ob_bad, hb);
      for (int r = 0; r < 4; r++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (ob[r] !== e) begin
            n_errors++; $display("FAIL reset_mid_identity[%0d]: got %h expected %h", r, ob[r], e);
         end
      end
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      rst_n = 1'b0; mat_we = 1'b0; mat_addr = 4'h0; mat_data = 16'h0;
      in_valid = 1'b0; in_x = 16'h0; in_y = 16'h0; in_z = 16'h0; in_w = 16'h0;
      dp_done = 1'b0; dp_result = 16'h0; out_ready = 1'b0;
      for (int i = 0; i < 16; i++) ref_m[i] = (i % 5 == 0) ? 16'h0100 : 16'h0000;
      test_reset();
      test_identity();
      test_row_load();
      test_hold();
      test_busy_write();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mvp_xform.md
MVP_XFORM -- requirements
Module: mvp_xform

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: mat_we  in  1  matrix word write strobe.
REQ-004 SHALL have: mat_addr  in  4  matrix word index, row*4+col.
REQ-005 SHALL have: mat_data  in  16  signed Q8.8 matrix word.
REQ-006 SHALL have: in_valid  in  1  vertex offered.
REQ-007 SHALL have: in_ready  out  1  high only in IDLE.
REQ-008 SHALL have: in_x, in_y, in_z, in_w  in  16 each  signed Q8.8 vertex.
REQ-009 SHALL have: dp_start  out  1  one-cycle dot-unit start pulse.
REQ-010 SHALL have: dp_a_x..dp_a_w  out  16 each  matrix row operand.
REQ-011 SHALL have: dp_b_x..dp_b_w  out  16 each  latched vertex operand.
REQ-012 SHALL have: dp_done  in  1  dot-unit result-valid pulse.
REQ-013 SHALL have: dp_result  in  16  signed Q8.8 dot result.
REQ-014 SHALL have: out_valid  out  1  transformed vertex available.
REQ-015 SHALL have: out_ready  in  1  consumer accepts.
REQ-016 SHALL have: out_x, out_y, out_z, out_w  out  16 each  signed Q8.8 result.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, OUT with 2-bit row counter.
REQ-018 IDLE: in_valid&in_ready latches in_x..in_w into vertex regs, row<=0, ->ISSUE.
REQ-019 ISSUE: dp_start=1 for exactly one cycle, dp_a = matrix row[row], ->WAIT.
REQ-020 dp_a/dp_b SHALL stay stable from ISSUE until dp_done is sampled.
REQ-021 WAIT: on dp_done, dp_result stored into out component [row]; if last row ->OUT else row+1, ->ISSUE.
REQ-022 dp_done outside WAIT SHALL be ignored.
REQ-023 OUT: out_valid=1, outputs held stable; out_valid&out_ready ->IDLE next cycle.
REQ-024 Back-to-back: new vertex accepted no earlier than cycle after output handshake.
REQ-025 Latency in_valid accept to out_valid = sum over rows of (2 + dot-unit latency) cycles.
REQ-026 mat_we SHALL write only in IDLE; writes in other states ignored; write in same cycle as vertex accept takes effect for that vertex.
REQ-027 No arithmetic inside block; out_* are dp_result bits passed unmodified.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, row=0, dp_start=0, out_valid=0, out_*=0, dp_a/dp_b=0, vertex regs=0.
REQ-029 Matrix SHALL reset to identity: diagonal 0x0100, others 0x0000.
REQ-030 Reset mid-operation SHALL abandon the vertex; later dp_done ignored.

Configuration
REQ-031 Macro XFORM_SKIP_W_EN: when defined, only rows 0..2 issued, out_w forced 0x0100, last row=2.
REQ-032 When undefined, all four rows issued, out_w = row 3 result.

Verification
REQ-033 Reset, vertex (0x0100,0x0200,0x0300,0x0100), identity matrix -> out=(0x0100,0x0200,0x0300,0x0100), four dp_start pulses.
REQ-034 Load row0=(0x0200,0,0,0), vertex x=0x0180, dot model -> out_x=0x0300.
REQ-035 Hold out_ready=0 for 10 cycles -> out_valid and out_* stable, in_ready=0, no dp_start.
REQ-036 mat_we during WAIT -> matrix unchanged, next vertex uses prior values.
REQ-037 Deassert rst_n during WAIT row 2 -> all outputs 0, in_ready=1 after release, stray dp_done ignored.
REQ-038 XFORM_SKIP_W_EN defined -> three dp_start pulses, out_w=0x0100.
